boot_loader: RTL and testbench

BOOT_LOADER -- requirements
Module: boot_loader

---
 rtl/boot_loader.sv | 221 ++++++++++++++++++++++
 tb/tb_boot_loader.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/boot_loader.sv
// ---------------------------------------------------------------------------
// boot_loader
//
// Receives a program over a byte stream and writes it into instruction memory
// one 32-bit word at a time. The processor is held in reset until the whole
// image has been written.
//
// Stream format: length low byte, length high byte (N = number of 32-bit
// words), 4*N program bytes packed little-endian, then one checksum byte
// when the checksum option is built in.
//
// Optional feature macro: BOOT_LOADER_CHECKSUM_EN
//   defined   -> program bytes are XOR-accumulated and one extra checksum byte
//                is consumed in the CHK state; a mismatch aborts the load.
//   undefined -> no CHK state, no accumulator, no checksum byte.
//
// Parameters:
//   ADDR_BASE  byte address of the first instruction word
//   MAX_WORDS  largest accepted program length in words
//
// Ports:
//   clk         single clock, rising edge
//   rst         asynchronous active-low reset
//   in_valid    byte offered on in_data
//   in_ready    loader accepts a byte (transfer = in_valid & in_ready)
//   in_data     stream byte
//   imem_we     one-cycle write strobe per word
//   imem_addr   write byte address (holds when imem_we=0)
//   imem_wdata  assembled word (holds when imem_we=0)
//   cpu_hold    1 keeps the processor in reset (0 only in DONE)
//   done        load finished successfully (terminal until reset)
//   err         load aborted (terminal until reset)
//   word_count  words written so far
//   state_dbg   current FSM state encoding
//
// Handshake: a byte moves on every rising edge where in_valid and in_ready
// are both 1. in_ready depends only on registered state, so it never reacts
// combinationally to in_valid.
// ---------------------------------------------------------------------------
module boot_loader #(
    parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
    parameter int          MAX_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_data,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        cpu_hold,
    output logic        done,
    output logic        err,
    output logic [15:0] word_count,
    output logic [2:0]  state_dbg
);

    typedef enum logic [2:0] {
        S_LEN0  = 3'd0,
        S_LEN1  = 3'd1,
        S_DATA  = 3'd2,
        S_WRITE = 3'd3,
`ifdef BOOT_LOADER_CHECKSUM_EN
        S_CHK   = 3'd4,
`endif
        S_DONE  = 3'd5,
        S_ERROR = 3'd6
    } state_t;

    localparam logic [16:0] LP_MAX_WORDS = 17'(MAX_WORDS);

    state_t      r_state;
    state_t      w_next;
    logic        r_active;      // low until the first edge after reset
    logic [15:0] r_len;
    logic [1:0]  r_byte_idx;
    logic [23:0] r_buf;         // first three bytes of the word in progress
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [15:0] r_word_count;
`ifdef BOOT_LOADER_CHECKSUM_EN
    logic [7:0]  r_csum;
`endif

    logic        w_xfer;
    logic [15:0] w_len_full;
    logic [15:0] w_wc_inc;

    assign w_xfer     = in_valid & in_ready;
    // High byte arrives in LEN1 while the low byte is already registered.
    assign w_len_full = {in_data, r_len[7:0]};
    assign w_wc_inc   = r_word_count + 16'd1;

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_LEN0;
        end else begin
            r_state <= w_next;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_LEN0: begin
                if (w_xfer) w_next = S_LEN1;
            end
            S_LEN1: begin
                if (w_xfer) begin
                    if (w_len_full == 16'd0) begin
`ifdef BOOT_LOADER_CHECKSUM_EN
                        w_next = S_CHK;
`else
                        w_next = S_DONE;
`endif
                    end else if ({1'b0, w_len_full} > LP_MAX_WORDS) begin
                        w_next = S_ERROR;
                    end else begin
                        w_next = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (w_xfer && (r_byte_idx == 2'd3)) w_next = S_WRITE;
            end
            S_WRITE: begin
                if (w_wc_inc < r_len) begin
                    w_next = S_DATA;
                end else begin
`ifdef BOOT_LOADER_CHECKSUM_EN
                    w_next = S_CHK;
`else
                    w_next = S_DONE;
`endif
                end
            end
`ifdef BOOT_LOADER_CHECKSUM_EN
            S_CHK: begin
                if (w_xfer) w_next = (in_data == r_csum) ? S_DONE : S_ERROR;
            end
`endif
            S_DONE:  w_next = S_DONE;
            S_ERROR: w_next = S_ERROR;
            default: w_next = S_LEN0;
        endcase
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_active     <= 1'b0;
            r_len        <= 16'd0;
            r_byte_idx   <= 2'd0;
            r_buf        <= 24'd0;
            r_addr       <= 32'd0;
            r_wdata      <= 32'd0;
            r_word_count <= 16'd0;
`ifdef BOOT_LOADER_CHECKSUM_EN
            r_csum       <= 8'd0;
`endif
        end else begin
            r_active <= 1'b1;
            case (r_state)
                S_LEN0: begin
                    if (w_xfer) r_len[7:0] <= in_data;
                end
                S_LEN1: begin
                    if (w_xfer) r_len[15:8] <= in_data;
                end
                S_DATA: begin
                    if (w_xfer) begin
`ifdef BOOT_LOADER_CHECKSUM_EN
                        r_csum <= r_csum ^ in_data;
`endif
                        case (r_byte_idx)
                            2'd0: r_buf[7:0]   <= in_data;
                            2'd1: r_buf[15:8]  <= in_data;
                            2'd2: r_buf[23:16] <= in_data;
                            default: begin
                                // Word complete: present it during the
                                // following WRITE cycle.
                                r_wdata <= {in_data, r_buf};
                                r_addr  <= ADDR_BASE + {14'd0, r_word_count, 2'b00};
                            end
                        endcase
                        r_byte_idx <= r_byte_idx + 2'd1;
                    end
                end
                S_WRITE: begin
                    r_word_count <= w_wc_inc;
                end
                default: ;
            endcase
        end
    end

    // ---------------- outputs ----------------
    always_comb begin
        in_ready = 1'b0;
        case (r_state)
            S_LEN0, S_LEN1, S_DATA: in_ready = r_active;
`ifdef BOOT_LOADER_CHECKSUM_EN
            S_CHK:                  in_ready = r_active;
`endif
            default:                in_ready = 1'b0;
        endcase
    end

    assign imem_we    = (r_state == S_WRITE);
    assign imem_addr  = r_addr;
    assign imem_wdata = r_wdata;
    assign cpu_hold   = (r_state != S_DONE);
    assign done       = (r_state == S_DONE);
    assign err        = (r_state == S_ERROR);
    assign word_count = r_word_count;
    assign state_dbg  = r_state;

endmodule

// File: tb/tb_boot_loader.sv
module tb_boot_loader;

    localparam logic [31:0] BASE = 32'h0000_0100;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_hold;
    logic        done;
    logic        err;
    logic [15:0] word_count;
    logic [2:0]  state_dbg;

    int total;
    int bad;

    logic [63:0] exp_q[$];   // {addr, data} of expected memory writes

    typedef struct {
        logic [95:0] stream;   // byte k at [8k +: 8]
        int          nb;
        bit          gaps;
        int          nw;
        logic [31:0] wa0, wd0, wa1, wd1;
        logic        exp_done;
        logic        exp_err;
        logic [15:0] exp_wc;
    } vec_t;

    vec_t vecs[6];

    boot_loader #(.ADDR_BASE(BASE), .MAX_WORDS(256)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .err        (err),
        .word_count (word_count),
        .state_dbg  (state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [95:0] bytes12(
        input logic [7:0] b0, b1, b2, b3, b4, b5,
        input logic [7:0] b6, b7, b8, b9, b10, b11);
        return {b11, b10, b9, b8, b7, b6, b5, b4, b3, b2, b1, b0};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        in_data = 8'h00;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    // Offer one byte; returns at the negedge just before the accepting edge.
    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int t;
        t = 0;
        if (gaps) begin
            repeat ($urandom_range(0, 3)) begin
                @(negedge clk);
                in_valid = 1'b0;
                in_data = 8'hEE;
            end
        end
        @(negedge clk);
        in_valid = 1'b1;
        in_data = b;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) begin
            total++;
            bad++;
            $display("FAIL send_byte timeout: in_ready=%0b expected 1", in_ready);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (rst && imem_we) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: addr=%0h data=%0h expected none", imem_addr, imem_wdata);
            end else begin
                chk("imem_write", {imem_addr, imem_wdata}, exp_q.pop_front());
            end
        end
    end

    task automatic run_vec(input int i);
        do_reset();
        if (vecs[i].nw > 0) exp_q.push_back({vecs[i].wa0, vecs[i].wd0});
        if (vecs[i].nw > 1) exp_q.push_back({vecs[i].wa1, vecs[i].wd1});
        for (int k = 0; k < vecs[i].nb; k++) send_byte(vecs[i].stream[8*k +: 8], vecs[i].gaps);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk($sformatf("v%0d_done", i), 64'(done), 64'(vecs[i].exp_done));
        chk($sformatf("v%0d_err", i), 64'(err), 64'(vecs[i].exp_err));
        chk($sformatf("v%0d_cpu_hold", i), 64'(cpu_hold), 64'(!vecs[i].exp_done));
        chk($sformatf("v%0d_word_count", i), 64'(word_count), 64'(vecs[i].exp_wc));
        chk($sformatf("v%0d_in_ready", i), 64'(in_ready), 64'd0);
        chk($sformatf("v%0d_writes_left", i), 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    // ---------------- test ----------------
    initial begin
        total = 0;
        bad = 0;
        rst = 1'b0;
        in_valid = 1'b0;
        in_data = 8'h00;

        // Vector table. Checksum of the two-word program is 13^93^10 = 8'h90.
`ifdef BOOT_LOADER_CHECKSUM_EN
        vecs[0] = '{bytes12(8'h02,8'h00,8'h13,8'h00,8'h00,8'h00,8'h93,8'h00,8'h10,8'h00,8'h90,8'h00), 11, 1'b0,
                    2, BASE, 32'h0000_0013, BASE + 32'd4, 32'h0010_0093, 1'b1, 1'b0, 16'd2};
        vecs[1] = '{bytes12(8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00), 3, 1'b0,
                    0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0, 16'd0};
        vecs[3] = '{bytes12(8'h02,8'h00,8'h13,8'h00,8'h00,8'h00,8'h93,8'h00,8'h10,8'h00,8'h90,8'h00), 11, 1'b1,
                    2, BASE, 32'h0000_0013, BASE + 32'd4, 32'h0010_0093, 1'b1, 1'b0, 16'd2};
        vecs[4] = '{bytes12(8'h01,8'h00,8'h11,8'h22,8'h33,8'h44,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00), 7, 1'b0,
                    1, BASE, 32'h4433_2211, 32'd0, 32'd0, 1'b0, 1'b1, 16'd1};
        vecs[5] = '{bytes12(8'h01,8'h00,8'h11,8'h22,8'h33,8'h44,8'h44,8'h00,8'h00,8'h00,8'h00,8'h00), 7, 1'b1,
                    1, BASE, 32'h4433_2211, 32'd0, 32'd0, 1'b1, 1'b0, 16'd1};
`else
        vecs[0] = '{bytes12(8'h02,8'h00,8'h13,8'h00,8'h00,8'h00,8'h93,8'h00,8'h10,8'h00,8'h00,8'h00), 10, 1'b0,
                    2, BASE, 32'h0000_0013, BASE + 32'd4, 32'h0010_0093, 1'b1, 1'b0, 16'd2};
        vecs[1] = '{bytes12(8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00), 2, 1'b0,
                    0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0, 16'd0};
        vecs[3] = '{bytes12(8'h02,8'h00,8'h13,8'h00,8'h00,8'h00,8'h93,8'h00,8'h10,8'h00,8'h00,8'h00), 10, 1'b1,
                    2, BASE, 32'h0000_0013, BASE + 32'd4, 32'h0010_0093, 1'b1, 1'b0, 16'd2};
        vecs[4] = '{bytes12(8'h01,8'h00,8'h11,8'h22,8'h33,8'h44,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00), 6, 1'b0,
                    1, BASE, 32'h4433_2211, 32'd0, 32'd0, 1'b1, 1'b0, 16'd1};
        vecs[5] = '{bytes12(8'h01,8'h00,8'h11,8'h22,8'h33,8'h44,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00), 6, 1'b1,
                    1, BASE, 32'h4433_2211, 32'd0, 32'd0, 1'b1, 1'b0, 16'd1};
`endif
        // Length 257 exceeds MAX_WORDS in both builds.
        vecs[2] = '{bytes12(8'h01,8'h01,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00), 2, 1'b0,
                    0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1, 16'd0};

        // Reset values while rst is held low.
        #12;
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_imem_we", 64'(imem_we), 64'd0);
        chk("rst_imem_addr", 64'(imem_addr), 64'd0);
        chk("rst_imem_wdata", 64'(imem_wdata), 64'd0);
        chk("rst_cpu_hold", 64'(cpu_hold), 64'd1);
        chk("rst_done_err", 64'({done, err}), 64'd0);
        chk("rst_word_count", 64'(word_count), 64'd0);
        chk("rst_state", 64'(state_dbg), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("ready_before_edge", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        chk("ready_after_edge", 64'(in_ready), 64'd1);

        // Table-driven streams.
        for (int i = 0; i < 6; i++) run_vec(i);

        // Write latency: strobe one cycle after the 4th byte is accepted.
        do_reset();
        exp_q.push_back({BASE, 32'hDDCC_BBAA});
        send_byte(8'h01, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b0);
        send_byte(8'hCC, 1'b0);
        send_byte(8'hDD, 1'b0);
        @(negedge clk);
        chk("lat_imem_we", 64'(imem_we), 64'd1);
        chk("lat_in_ready", 64'(in_ready), 64'd0);
`ifdef BOOT_LOADER_CHECKSUM_EN
        send_byte(8'h00, 1'b0);   // AA^BB^CC^DD = 00
        @(negedge clk);
`endif
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("lat_done", 64'(done), 64'd1);
        chk("lat_hold_addr", 64'(imem_addr), 64'(BASE));
        chk("lat_writes_left", 64'(exp_q.size()), 64'd0);
        exp_q.delete();

        // N = MAX_WORDS is accepted.
        do_reset();
        send_byte(8'h00, 1'b0);
        send_byte(8'h01, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        chk("max_state_data", 64'(state_dbg), 64'd2);
        chk("max_in_ready", 64'(in_ready), 64'd1);
        chk("max_err", 64'(err), 64'd0);

        // Reset mid-word, then a fresh stream.
        do_reset();
        send_byte(8'h02, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b0;
        #1;
        chk("midword_rst_state", 64'(state_dbg), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        exp_q.push_back({BASE, 32'h4433_2211});
        send_byte(8'h01, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b0);
        send_byte(8'h44, 1'b0);
`ifdef BOOT_LOADER_CHECKSUM_EN
        send_byte(8'h44, 1'b0);
`endif
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("fresh_done", 64'(done), 64'd1);
        chk("fresh_word_count", 64'(word_count), 64'd1);
        chk("fresh_writes_left", 64'(exp_q.size()), 64'd0);
        exp_q.delete();

        // Reset during the WRITE cycle: strobe drops at once, no write lands.
        do_reset();
        send_byte(8'h01, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h03, 1'b0);
        send_byte(8'h04, 1'b0);
        @(posedge clk);
        #1;
        chk("midwr_we_before", 64'(imem_we), 64'd1);
        rst = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("midwr_we_after", 64'(imem_we), 64'd0);
        chk("midwr_wdata", 64'(imem_wdata), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("midwr_word_count", 64'(word_count), 64'd0);
        chk("midwr_state", 64'(state_dbg), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
